regfile_read_port: RTL and testbench
====================================

# regfile_read_port

Read side of the CPU's 32-entry general-purpose register file. Accepts a decode-stage request for two source registers (rs, rt), returns both operands one cycle later through a registered valid/ready output stage, and owns the storage array that the writeback stage fills. Sits between decode and execute. Provides write-to-read forwarding, so execute never sees a stale operand.

## Interface
- WIDTH, 32, data width of each register
- ADDR_W, 5, register address width; depth is 2**ADDR_W
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  decode presents a read request
- req_ready  output  1  block can accept a request this cycle
- rs_addr  input  ADDR_W  first source register index
- rt_addr  input  ADDR_W  second source register index
- wb_en  input  1  writeback write enable
- wb_addr  input  ADDR_W  writeback destination index
- wb_data  input  WIDTH  writeback data
- rsp_valid  output  1  operands valid to execute
- rsp_ready  input  1  execute consumes the response
- rs_data  output  WIDTH  operand for rs_addr
- rt_data  output  WIDTH  operand for rt_addr
- rs_tag  output  ADDR_W  rs_addr of the held response
- rt_tag  output  ADDR_W  rt_addr of the held response

## Operation
- Storage: 2**ADDR_W words of WIDTH. Entry 0 is hardwired to zero. Writes to address 0 are dropped. Reads of address 0 return 0.
- Write: on a rising edge with wb_en=1 and wb_addr≠0, mem[wb_addr] <= wb_data.
- Output stage: a single-entry register holding valid, rs_data, rt_data, rs_tag and rt_tag.
- req_ready = !rsp_valid || rsp_ready (combinational). No skid entry.
- Accept: the request is taken when req_valid && req_ready. Next cycle:
  - rsp_valid=1;
  - tags = the requested addresses;
  - each operand = wb_data if wb_en && wb_addr==addr && addr≠0, else mem[addr] (same-edge forwarding);
  - each operand = 0 if addr==0.
- Consume without a new accept: when rsp_valid && rsp_ready and no new request is accepted, rsp_valid goes to 0. Data and tags hold their last values.
- Stall refresh: while rsp_valid && !rsp_ready, a writeback with wb_en && wb_addr≠0 updates the matching held operand(s) with wb_data. rs_tag==rt_tag updates both. The held operand always equals current architectural state.
- Simultaneous consume and accept: the new response replaces the old one; rsp_valid stays 1.
- wb_en with wb_addr=0: no effect anywhere, including forwarding and refresh.
- rs_addr==rt_addr: both operands are identical in every case.

## Timing
- Reset (reset_n=0, asynchronous) forces:
  - all mem entries = 0;
  - rsp_valid=0;
  - rs_data, rt_data, rs_tag, rt_tag = 0;
  - req_ready therefore reads 1 during reset.
- Reset asserted mid-stall discards the held response. No response is emitted after release until a new accept.
- Latency: accept at edge N gives rsp_valid=1 after edge N. Back-to-back throughput is 1 per cycle while rsp_ready=1.
- A writeback on edge N is visible to a request accepted on edge N (forwarded) and to any later request (from mem).
- Outputs are registered. Only req_ready is combinational, from rsp_valid and rsp_ready. There is no combinational path from wb_* to any output.

## Test plan
- Reset, then read: reset_n low then high, request rs=3, rt=7 -> rsp_valid=1 next cycle, rs_data=0, rt_data=0, tags 3/7.
- Write then read: wb r5=0xDEADBEEF at edge N, request rs=5, rt=0 at edge N+1 -> rs_data=0xDEADBEEF, rt_data=0.
- Same-edge forward: wb r9=0x12345678 and request rs=9, rt=9 on the same edge -> both operands 0x12345678 next cycle. Also wb r0=0xFFFFFFFF, then read r0 -> 0.
- Stall with refresh: request rs=4 (holding 0x1), hold rsp_ready=0 for 3 cycles, and during the stall wb r4=0xAA -> rs_data becomes 0xAA the following cycle, rsp_valid stays 1, req_ready=0 throughout the stall.
- Streaming: 8 consecutive requests with rsp_ready=1 -> 8 responses on 8 consecutive cycles, in order, correct tags, no bubbles.
- Async reset mid-stall: drop reset_n between edges while rsp_valid=1 -> rsp_valid=0 immediately without waiting for a clock edge, and a previously written register reads 0 afterwards.

Source files
------------

// File: rtl/regfile_read_port.sv
// Register file read port: 32-entry storage plus a registered
// two-operand response stage with writeback forwarding.
module regfile_read_port #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rs_data,
  output logic [WIDTH-1:0]  rt_data,
  output logic [ADDR_W-1:0] rs_tag,
  output logic [ADDR_W-1:0] rt_tag
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  logic              wb_hit;
  logic              accept;
  logic              drain;
  logic              stall;
  logic [WIDTH-1:0]  rs_rd;
  logic [WIDTH-1:0]  rt_rd;

  logic              v_nxt;
  logic [WIDTH-1:0]  rs_nxt;
  logic [WIDTH-1:0]  rt_nxt;
  logic [ADDR_W-1:0] rst_nxt;
  logic [ADDR_W-1:0] rtt_nxt;

  assign wb_hit    = wb_en && (wb_addr != '0);
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign drain     = rsp_valid && rsp_ready && !req_valid;
  assign stall     = rsp_valid && !rsp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wb_hit) begin
      mem[wb_addr] <= wb_data;
    end
  end

  // Forwarded read: same-edge writeback wins over stored value
  always_comb begin
    rs_rd = mem[rs_addr];
    rt_rd = mem[rt_addr];
    if (wb_hit && wb_addr == rs_addr) rs_rd = wb_data;
    if (wb_hit && wb_addr == rt_addr) rt_rd = wb_data;
    if (rs_addr == '0) rs_rd = '0;
    if (rt_addr == '0) rt_rd = '0;
  end

  always_comb begin
    v_nxt   = rsp_valid;
    rs_nxt  = rs_data;
    rt_nxt  = rt_data;
    rst_nxt = rs_tag;
    rtt_nxt = rt_tag;
    unique case (1'b1)
      accept: begin
        v_nxt   = 1'b1;
        rs_nxt  = rs_rd;
        rt_nxt  = rt_rd;
        rst_nxt = rs_addr;
        rtt_nxt = rt_addr;
      end
      drain: v_nxt = 1'b0;
      stall: begin
        // Keep held operands equal to architectural state
        if (wb_hit && wb_addr == rs_tag) rs_nxt = wb_data;
        if (wb_hit && wb_addr == rt_tag) rt_nxt = wb_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rs_data   <= '0;
      rt_data   <= '0;
      rs_tag    <= '0;
      rt_tag    <= '0;
    end else begin
      rsp_valid <= v_nxt;
      rs_data   <= rs_nxt;
      rt_data   <= rt_nxt;
      rs_tag    <= rst_nxt;
      rt_tag    <= rtt_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: vector table, directed corner
// sequences and a randomized run against an architectural model.
module tb_regfile_read_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [4:0]  rs_tag;
  logic [4:0]  rt_tag;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_read_port #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rs_data(rs_data), .rt_data(rt_data),
    .rs_tag(rs_tag), .rt_tag(rt_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        req_valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rsp_ready;
    logic        e_rdy;
    logic        e_v;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [4:0]  e_rst;
    logic [4:0]  e_rtt;
  } vec_t;

  vec_t vecs[8];

  // Architectural model: register contents and expected response state
  logic [31:0] arch [32];
  logic        mv;
  logic [4:0]  m_rst;
  logic [4:0]  m_rtt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic rv,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic rr);
    wb_en = we; wb_addr = wa; wb_data = wd;
    req_valid = rv; rs_addr = rs; rt_addr = rt;
    rsp_ready = rr;
  endtask

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b1,
                1'b1, 1'b0, 32'h0, 32'h0, 5'd3, 5'd7};
    vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 1'b1,
                1'b1, 1'b1, 32'hDEADBEEF, 32'h0, 5'd5, 5'd0};
    vecs[2] = '{1'b1, 5'd9, 32'h12345678, 1'b1, 5'd9, 5'd9, 1'b1,
                1'b1, 1'b1, 32'h12345678, 32'h12345678, 5'd9, 5'd9};
    vecs[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 1'b1,
                1'b1, 1'b0, 32'h12345678, 32'h12345678, 5'd9, 5'd9};
    vecs[4] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b1,
                1'b1, 1'b1, 32'h0, 32'h0, 5'd0, 5'd0};
    vecs[5] = '{1'b1, 5'd5, 32'h55, 1'b1, 5'd5, 5'd9, 1'b1,
                1'b1, 1'b1, 32'h55, 32'h12345678, 5'd5, 5'd9};
    vecs[6] = '{1'b1, 5'd9, 32'h99, 1'b1, 5'd1, 5'd1, 1'b0,
                1'b0, 1'b1, 32'h55, 32'h99, 5'd5, 5'd9};
    vecs[7] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1,
                1'b1, 1'b0, 32'h55, 32'h99, 5'd5, 5'd9};

    reset_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_rs", rs_data, 32'h0);
    chk("rst_tags", {22'h0, rs_tag, rt_tag}, 32'h0);
    reset_n = 1'b1;

    // Reset then read
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd7, 1'b1);
    cyc();
    chk("rd37_valid", 32'(rsp_valid), 32'h1);
    chk("rd37_rs", rs_data, 32'h0);
    chk("rd37_rt", rt_data, 32'h0);
    chk("rd37_tags", {22'h0, rs_tag, rt_tag}, {22'h0, 5'd3, 5'd7});

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].wb_en, vecs[i].wb_addr, vecs[i].wb_data,
            vecs[i].req_valid, vecs[i].rs, vecs[i].rt,
            vecs[i].rsp_ready);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      cyc();
      chk($sformatf("v%0d_valid", i), 32'(rsp_valid), 32'(vecs[i].e_v));
      chk($sformatf("v%0d_rs", i), rs_data, vecs[i].e_rs);
      chk($sformatf("v%0d_rt", i), rt_data, vecs[i].e_rt);
      chk($sformatf("v%0d_tags", i), {22'h0, rs_tag, rt_tag},
          {22'h0, vecs[i].e_rst, vecs[i].e_rtt});
    end

    // Streaming: one response per cycle, no bubbles
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i + 1), 5'(i), 1'b1);
      cyc();
      chk($sformatf("st%0d_valid", i), 32'(rsp_valid), 32'h1);
      chk($sformatf("st%0d_tags", i), {22'h0, rs_tag, rt_tag},
          {22'h0, 5'(i + 1), 5'(i)});
    end

    // Stall with refresh
    drive(1'b1, 5'd4, 32'h1, 1'b0, 5'd0, 5'd0, 1'b1);
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 1'b1);
    cyc();
    chk("stl_rs0", rs_data, 32'h1);
    for (int i = 0; i < 3; i++) begin
      drive(i == 1, 5'd4, 32'hAA, 1'b1, 5'd6, 5'd6, 1'b0);
      #1;
      chk($sformatf("stl%0d_ready", i), 32'(req_ready), 32'h0);
      cyc();
      chk($sformatf("stl%0d_valid", i), 32'(rsp_valid), 32'h1);
      chk($sformatf("stl%0d_rs", i), rs_data, i == 0 ? 32'h1 : 32'hAA);
      chk($sformatf("stl%0d_tag", i), 32'(rs_tag), 32'd4);
    end

    // Async reset while stalled
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", 32'(rsp_valid), 32'h0);
    chk("ar_ready", 32'(req_ready), 32'h1);
    chk("ar_rs", rs_data, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1);
    cyc();
    chk("ar_noemit", 32'(rsp_valid), 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd5, 1'b1);
    cyc();
    chk("ar_rd_valid", 32'(rsp_valid), 32'h1);
    chk("ar_rd_r4", rs_data, 32'h0);
    chk("ar_rd_r5", rt_data, 32'h0);

    // Randomized run against the architectural model
    for (int i = 0; i < 32; i++) arch[i] = 32'h0;
    mv = 1'b1;
    m_rst = 5'd4;
    m_rtt = 5'd5;
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(1, 0) == 1,
            5'($urandom_range(9, 0)), $urandom,
            $urandom_range(9, 0) < 7,
            5'($urandom_range(9, 0)), 5'($urandom_range(9, 0)),
            $urandom_range(9, 0) < 6);
      #1;
      chk("rnd_ready", 32'(req_ready), 32'(!mv || rsp_ready));
      @(posedge clk);
      if (wb_en && wb_addr != 0) arch[wb_addr] = wb_data;
      if (req_valid && (!mv || rsp_ready)) begin
        mv = 1'b1;
        m_rst = rs_addr;
        m_rtt = rt_addr;
      end else if (mv && rsp_ready) begin
        mv = 1'b0;
      end
      @(negedge clk);
      chk("rnd_valid", 32'(rsp_valid), 32'(mv));
      if (mv) begin
        chk("rnd_tags", {22'h0, rs_tag, rt_tag}, {22'h0, m_rst, m_rtt});
        chk("rnd_rs", rs_data, arch[m_rst]);
        chk("rnd_rt", rt_data, arch[m_rtt]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
